// File: rtl/inst_cache_param_if.sv
// Fetch-side and memory-side handshake bundle for inst_cache_param.
interface inst_cache_param_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  addr_valid;
  logic                  flush;
  logic [INST_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_addr_o;
  logic                  inst_ready;
  logic                  inst_needed;
  logic [ADDR_WIDTH-1:0] addr_to_mem;
  logic                  inst_available;
  logic [INST_WIDTH-1:0] inst_from_mem;

  modport master (
    output inst_addr, addr_valid, flush, inst_available, inst_from_mem,
    input  inst, inst_addr_o, inst_ready, inst_needed, addr_to_mem
  );

  modport slave (
    input  inst_addr, addr_valid, flush, inst_available, inst_from_mem,
    output inst, inst_addr_o, inst_ready, inst_needed, addr_to_mem
  );
endinterface

// File: rtl/inst_cache_param.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding miss.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module inst_cache_param #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int INDEX_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  inst_cache_param_if.slave      bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
`endif
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t                 r_state, w_state_nxt;
  logic [LINES-1:0]       r_valid;
  logic [TAG_WIDTH-1:0]   r_tag  [LINES];
  logic [INST_WIDTH-1:0]  r_data [LINES];
  logic [ADDR_WIDTH-1:0]  r_miss_addr;
  logic [INST_WIDTH-1:0]  r_inst;
  logic [ADDR_WIDTH-1:0]  r_inst_addr;
  logic                   r_inst_ready;
  logic                   r_inst_needed;

  logic [INDEX_WIDTH-1:0] w_req_idx, w_fill_idx;
  logic [TAG_WIDTH-1:0]   w_req_tag, w_fill_tag;
  logic                   w_line_hit;
  logic                   w_hit, w_miss, w_fill;

  assign w_req_idx  = bus.inst_addr[INDEX_WIDTH+1:2];
  assign w_req_tag  = bus.inst_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign w_fill_idx = r_miss_addr[INDEX_WIDTH+1:2];
  assign w_fill_tag = r_miss_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign w_line_hit = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // flush overrides every transition, so a fill or new request in that cycle is dropped
  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    w_fill      = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.addr_valid) begin
            if (w_line_hit) begin
              w_hit = 1'b1;
            end else begin
              w_miss      = 1'b1;
              w_state_nxt = S_MISS;
            end
          end
        end
        S_MISS: begin
          if (bus.inst_available) begin
            w_fill      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) r_valid <= '0;
    else if (w_fill)      r_valid[w_fill_idx] <= 1'b1;
  end

  // Tag/data carry no reset so they can map onto plain RAM
  always_ff @(posedge clk) begin
    if (w_fill && !rst) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.inst_from_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst        <= '0;
      r_inst_addr   <= '0;
      r_inst_ready  <= 1'b0;
      r_inst_needed <= 1'b0;
      r_miss_addr   <= '0;
    end else begin
      r_inst_ready <= w_hit | w_fill;
      if (w_hit) begin
        r_inst      <= r_data[w_req_idx];
        r_inst_addr <= bus.inst_addr;
      end else if (w_fill) begin
        r_inst      <= bus.inst_from_mem;
        r_inst_addr <= r_miss_addr;
      end
      if (w_miss) begin
        r_miss_addr   <= bus.inst_addr;
        r_inst_needed <= 1'b1;
      end else if (w_fill || bus.flush) begin
        r_inst_needed <= 1'b0;
      end
    end
  end

  assign bus.inst        = r_inst;
  assign bus.inst_addr_o = r_inst_addr;
  assign bus.inst_ready  = r_inst_ready;
  assign bus.inst_needed = r_inst_needed;
  assign bus.addr_to_mem = {r_miss_addr[ADDR_WIDTH-1:2], 2'b00};

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // Saturating; flush deliberately leaves the counts alone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit  && (r_hit_cnt  != 32'hFFFF_FFFF)) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif
endmodule

// File: tb/tb_inst_cache_param.sv
// Bench for inst_cache_param: directed scenarios then random fetch traffic vs a line-level model.
module tb_inst_cache_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_cache_param_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  inst_cache_param #(.ADDR_WIDTH(32), .INST_WIDTH(32), .INDEX_WIDTH(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: each of the 128 lines remembers which word address it holds.
  bit          m_valid [128];
  logic [29:0] m_word  [128];
  logic [31:0] m_data  [128];
  logic [31:0] m_last_inst, m_last_addr;
  int          m_hits, m_miss;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear_lines();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear_lines();
    m_hits = 0;
    m_miss = 0;
    m_last_inst = '0;
    m_last_addr = '0;
  endtask

  task automatic chk_stats(input string tag);
`ifdef ICACHE_STATS_EN
    chk({tag, "_hits"}, 64'(hit_count), 64'(m_hits));
    chk({tag, "_miss"}, 64'(miss_count), 64'(m_miss));
`endif
  endtask

  // One fetch: hit returns next cycle; miss holds inst_needed for lat cycles then fills with d.
  task automatic req(input logic [31:0] a, input int lat, input logic [31:0] d);
    int idx;
    bit hit;
    idx = int'((a >> 2) % 128);
    hit = m_valid[idx] && (m_word[idx] == a[31:2]);
    bus.inst_addr      = a;
    bus.addr_valid     = 1'b1;
    bus.inst_available = 1'($urandom_range(0, 1));
    bus.inst_from_mem  = $urandom;
    step();
    bus.addr_valid     = 1'b0;
    bus.inst_available = 1'b0;
    if (hit) begin
      m_hits++;
      m_last_inst = m_data[idx];
      m_last_addr = a;
      chk("hit_ready",  64'(bus.inst_ready),  64'd1);
      chk("hit_inst",   64'(bus.inst),        64'(m_last_inst));
      chk("hit_addr",   64'(bus.inst_addr_o), 64'(a));
      chk("hit_needed", 64'(bus.inst_needed), 64'd0);
    end else begin
      m_miss++;
      chk("miss_needed",  64'(bus.inst_needed), 64'd1);
      chk("miss_memaddr", 64'(bus.addr_to_mem), 64'({a[31:2], 2'b00}));
      chk("miss_noready", 64'(bus.inst_ready),  64'd0);
      for (int i = 1; i < lat; i++) begin
        bus.addr_valid = 1'($urandom_range(0, 1));
        bus.inst_addr  = $urandom;
        step();
        chk("wait_needed",  64'(bus.inst_needed), 64'd1);
        chk("wait_memaddr", 64'(bus.addr_to_mem), 64'({a[31:2], 2'b00}));
        chk("wait_noready", 64'(bus.inst_ready),  64'd0);
        chk("wait_hold",    64'(bus.inst),        64'(m_last_inst));
      end
      bus.addr_valid     = 1'($urandom_range(0, 1));
      bus.inst_addr      = $urandom;
      bus.inst_available = 1'b1;
      bus.inst_from_mem  = d;
      step();
      bus.inst_available = 1'b0;
      bus.addr_valid     = 1'b0;
      m_valid[idx] = 1'b1;
      m_word[idx]  = a[31:2];
      m_data[idx]  = d;
      m_last_inst  = d;
      m_last_addr  = a;
      chk("fill_ready",  64'(bus.inst_ready),  64'd1);
      chk("fill_inst",   64'(bus.inst),        64'(d));
      chk("fill_addr",   64'(bus.inst_addr_o), 64'(a));
      chk("fill_needed", 64'(bus.inst_needed), 64'd0);
    end
  endtask

  task automatic flush_cycle(input bit with_req);
    bus.flush      = 1'b1;
    bus.addr_valid = with_req;
    bus.inst_addr  = $urandom;
    step();
    bus.flush      = 1'b0;
    bus.addr_valid = 1'b0;
    model_clear_lines();
    chk("flush_ready",  64'(bus.inst_ready),  64'd0);
    chk("flush_needed", 64'(bus.inst_needed), 64'd0);
    chk("flush_hold",   64'(bus.inst),        64'(m_last_inst));
  endtask

  initial begin
    rst = 1'b1;
    bus.inst_addr = '0; bus.addr_valid = 1'b0; bus.flush = 1'b0;
    bus.inst_available = 1'b0; bus.inst_from_mem = '0;
    model_reset();
    step();
    step();
    chk("rst_ready",   64'(bus.inst_ready),  64'd0);
    chk("rst_needed",  64'(bus.inst_needed), 64'd0);
    chk("rst_memaddr", 64'(bus.addr_to_mem), 64'd0);
    chk("rst_inst",    64'(bus.inst),        64'd0);
    chk("rst_addr",    64'(bus.inst_addr_o), 64'd0);
    chk_stats("rst");
    rst = 1'b0;

    // Cold miss, memory answers after 3 cycles
    req(32'h0000_1000, 3, 32'h0000_0013);
    step();
    chk("post_fill_ready", 64'(bus.inst_ready), 64'd0);
    chk("post_fill_hold",  64'(bus.inst),       64'h13);

    // Hit streak
    req(32'h0000_1004, 2, 32'hA0A0_0001);
    req(32'h0000_1008, 1, 32'hA0A0_0002);
    req(32'h0000_1000, 1, 32'h0);
    req(32'h0000_1004, 1, 32'h0);
    req(32'h0000_1008, 1, 32'h0);

    // Conflict at the same index
    req(32'h0000_1200, 2, 32'hC0FF_EE00);
    req(32'h0000_1000, 2, 32'h0000_0013);

    // Flush together with the fill
    bus.inst_addr = 32'h0000_2000; bus.addr_valid = 1'b1;
    step();
    bus.addr_valid = 1'b0;
    m_miss++;
    chk("fm_needed", 64'(bus.inst_needed), 64'd1);
    step();
    bus.inst_available = 1'b1; bus.inst_from_mem = 32'hDEAD_BEEF;
    flush_cycle(1'b0);
    bus.inst_available = 1'b0;
    step();
    chk("fm_quiet", 64'(bus.inst_ready), 64'd0);
    req(32'h0000_2000, 2, 32'h1234_5678);
    req(32'h0000_1000, 1, 32'h0000_0013);

    // Reset in the middle of a miss, with competing flush and fill
    req(32'h0000_3000, 1, 32'h0000_AAAA);
    bus.inst_addr = 32'h0000_3404; bus.addr_valid = 1'b1;
    step();
    bus.addr_valid = 1'b0;
    chk("rm_needed", 64'(bus.inst_needed), 64'd1);
    rst = 1'b1; bus.inst_available = 1'b1; bus.flush = 1'b1; bus.inst_from_mem = 32'h5555_5555;
    step();
    rst = 1'b0; bus.inst_available = 1'b0; bus.flush = 1'b0;
    model_reset();
    chk("rm_ready",   64'(bus.inst_ready),  64'd0);
    chk("rm_needed0", 64'(bus.inst_needed), 64'd0);
    chk("rm_memaddr", 64'(bus.addr_to_mem), 64'd0);
    chk("rm_inst",    64'(bus.inst),        64'd0);
    chk("rm_addr",    64'(bus.inst_addr_o), 64'd0);
    chk_stats("rm");

    // One miss, five hits, then flush and reset on the counters
    req(32'h0000_3000, 2, 32'h0000_BBBB);
    for (int i = 0; i < 5; i++) req(32'h0000_3000, 1, 32'h0);
    chk_stats("stats15");
    flush_cycle(1'b0);
    chk_stats("stats_flush");
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk_stats("stats_rst");

    // Random traffic over a small tag/index pool so hits, conflicts and misses all occur
    for (int it = 0; it < 300; it++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 19));
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if (r == 0) begin
        flush_cycle(1'b1);
      end else if (r == 1) begin
        bus.inst_available = 1'($urandom_range(0, 1));
        bus.inst_from_mem  = $urandom;
        step();
        bus.inst_available = 1'b0;
        chk("idle_ready",  64'(bus.inst_ready),  64'd0);
        chk("idle_needed", 64'(bus.inst_needed), 64'd0);
        chk("idle_hold",   64'(bus.inst_addr_o), 64'(m_last_addr));
      end else begin
        req(a, int'($urandom_range(1, 4)), $urandom);
      end
    end
    chk_stats("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_cache_param.md
INST_CACHE_PARAM -- requirements
Module: inst_cache_param

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 32, meaning instruction address width in bits.
REQ-002 The block SHALL take parameter INST_WIDTH, default 32, meaning instruction word width in bits.
REQ-003 The block SHALL take parameter INDEX_WIDTH, default 7, meaning log2 of line count (128 one-word lines, direct-mapped).
REQ-004 The block SHALL use derived TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2; index = inst_addr[INDEX_WIDTH+1:2]; tag = inst_addr[ADDR_WIDTH-1:INDEX_WIDTH+2].
REQ-005 The block SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port inst_addr  input  ADDR_WIDTH  fetch address from IF.
REQ-008 The block SHALL have port addr_valid  input  1  IF request strobe, sampled only in IDLE.
REQ-009 The block SHALL have port flush  input  1  invalidate all lines and cancel any pending miss.
REQ-010 The block SHALL have port inst  output  INST_WIDTH  returned instruction.
REQ-011 The block SHALL have port inst_addr_o  output  ADDR_WIDTH  address of returned instruction.
REQ-012 The block SHALL have port inst_ready  output  1  one-cycle pulse, inst/inst_addr_o valid.
REQ-013 The block SHALL have port inst_needed  output  1  miss request to mem-control, level, held until served.
REQ-014 The block SHALL have port addr_to_mem  output  ADDR_WIDTH  miss address, word-aligned (bits [1:0] = 0).
REQ-015 The block SHALL have port inst_available  input  1  mem-control data-valid pulse.
REQ-016 The block SHALL have port inst_from_mem  input  INST_WIDTH  fill data, valid with inst_available.

Function
REQ-017 The block SHALL hold per-line storage: valid bit, TAG_WIDTH tag, INST_WIDTH data.
REQ-018 The block SHALL implement states IDLE and MISS only.
REQ-019 In IDLE with addr_valid=1 and valid[index] and tag match (hit), the block SHALL, at the next edge, drive inst=data[index], inst_addr_o=inst_addr, inst_ready=1 (latency 1 cycle), remaining in IDLE.
REQ-020 Back-to-back hits SHALL be accepted every cycle, giving one inst_ready per cycle.
REQ-021 In IDLE with addr_valid=1 and no hit, the block SHALL latch the address, enter MISS, and assert inst_needed=1 and addr_to_mem=latched address from the next cycle.
REQ-022 In MISS, the block SHALL ignore addr_valid and inst_addr and hold inst_needed and addr_to_mem stable.
REQ-023 In MISS with inst_available=1, the block SHALL write valid=1, tag, and inst_from_mem into the line, drive inst_ready=1 with the fill word and latched address at the next edge, deassert inst_needed, and return to IDLE.
REQ-024 inst_ready SHALL be 0 in every cycle not covered by REQ-019 or REQ-023; inst and inst_addr_o SHALL hold their last values otherwise.
REQ-025 inst_available in IDLE SHALL be ignored.
REQ-026 flush=1 SHALL clear all valid bits at the edge, force state IDLE, deassert inst_needed next cycle, and suppress inst_ready for that edge.
REQ-027 flush and inst_available in the same cycle SHALL discard the fill: no array write and no inst_ready; flush has priority.
REQ-028 flush and addr_valid in the same cycle SHALL drop the request; IF re-presents it.
REQ-029 A line replaced by a fill SHALL overwrite the previous tag unconditionally (direct-mapped, no write-back).

Reset
REQ-030 rst=1 at an edge SHALL force IDLE, clear all valid bits, and set inst, inst_addr_o, inst_ready, inst_needed, and addr_to_mem to 0.
REQ-031 rst SHALL take priority over flush, inst_available, and addr_valid; rst during MISS SHALL abandon the miss without an array write.

Configuration
REQ-032 When macro ICACHE_STATS_EN is defined, the block SHALL add output ports hit_count and miss_count, each 32 bits wide.
REQ-033 With ICACHE_STATS_EN defined, hit_count SHALL increment per REQ-019 hit and miss_count per REQ-021 miss entry, saturating at 32'hFFFFFFFF, cleared only by rst (not flush).
REQ-034 Without ICACHE_STATS_EN, the ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 Cold miss: reset, addr_valid with inst_addr=0x0000_1000, mem returns 0x0000_0013 after 3 cycles -> addr_to_mem=0x1000 held 3 cycles; one inst_ready with inst=0x13, inst_addr_o=0x1000.
REQ-036 Hit streak: preload 0x1000, 0x1004, and 0x1008, then request them on consecutive cycles -> three consecutive inst_ready pulses, each 1 cycle after its request, inst_needed stays 0.
REQ-037 Conflict: fill 0x0000_1000, then request 0x0000_1200 (same index at INDEX_WIDTH=7) -> miss; a subsequent request to 0x1000 misses again.
REQ-038 Flush mid-miss: during MISS assert flush in the same cycle as inst_available -> no inst_ready, no write, inst_needed=0 next cycle; re-request the same address -> miss.
REQ-039 Reset mid-miss: rst during MISS -> all outputs 0 next cycle, a previously filled line now misses.
REQ-040 With ICACHE_STATS_EN: 1 miss plus 5 hits -> miss_count=1, hit_count=5; flush -> counters unchanged; rst -> both 0.
